usbfs_txn_ctrl: RTL and testbench



---
 rtl/usbfs_txn_ctrl_pkg.sv | 39 +++
 rtl/usbfs_turnaround_timer.sv | 29 ++
 rtl/usbfs_txn_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_usbfs_txn_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/usbfs_txn_ctrl_pkg.sv
// Shared USB full-speed constants: PID codes, PID group codes and the
// transaction controller state encoding.
package usbfs_txn_ctrl_pkg;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SOF   = 4'b0101;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    localparam logic [1:0] PIDGRP_SPECIAL = 2'b00;
    localparam logic [1:0] PIDGRP_TOKEN   = 2'b01;
    localparam logic [1:0] PIDGRP_HS      = 2'b10;
    localparam logic [1:0] PIDGRP_DATA    = 2'b11;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_DATA = 3'd1;
    localparam logic [2:0] ST_TX_HS     = 3'd2;
    localparam logic [2:0] ST_TX_DATA   = 3'd3;
    localparam logic [2:0] ST_WAIT_ACK  = 3'd4;

    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        WAIT_DATA = ST_WAIT_DATA,
        TX_HS     = ST_TX_HS,
        TX_DATA   = ST_TX_DATA,
        WAIT_ACK  = ST_WAIT_ACK
    } txnState_t;

    // Only DATA0/DATA1 are legal on a full-speed device; bit 3 is the toggle.
    function automatic logic isDataPid(input logic [3:0] pid);
        return (pid == PID_DATA0) || (pid == PID_DATA1);
    endfunction

endpackage

// File: rtl/usbfs_turnaround_timer.sv
// Host turnaround timer: down-counter loaded while cleared, flags expiry on
// the TIMEOUT_CYCLES-th enabled cycle after the clear is released.
module usbfs_turnaround_timer #(
    parameter int TIMEOUT_CYCLES = 72
) (
    input  logic i_clk_48MHz,
    input  logic i_rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LOAD = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count;

    always_ff @(posedge i_clk_48MHz or posedge i_rst) begin
        if (i_rst) begin
            count <= LOAD;
        end else if (clear) begin
            count <= LOAD;
        end else if (enable && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign expired = enable && (count == '0);

endmodule

// File: rtl/usbfs_txn_ctrl.sv
// USB full-speed device transaction sequencer: token/data/handshake phases,
// per-endpoint data toggles and host turnaround timeouts.
//
// state     | meaning
// IDLE      | waiting for a token addressed to this device
// WAIT_DATA | OUT/SETUP token accepted, waiting for the data packet
// TX_HS     | handshake (ACK/NAK/STALL) being transmitted
// TX_DATA   | IN data packet being transmitted
// WAIT_ACK  | IN data sent, waiting for the host ACK
module usbfs_txn_ctrl
    import usbfs_txn_ctrl_pkg::*;
#(
    parameter int N_EP           = 4,
    parameter int TIMEOUT_CYCLES = 72
) (
    input  logic            i_clk_48MHz,
    input  logic            i_rst,
    input  logic            i_usbReset,
    input  logic [6:0]      i_devAddr,
    input  logic            i_rx_eop,
    input  logic [3:0]      i_rx_pid,
    input  logic [6:0]      i_rx_addr,
    input  logic [3:0]      i_rx_endp,
    input  logic            i_rx_pidOkay,
    input  logic            i_rx_tokenOkay,
    input  logic            i_rx_dataOkay,
    input  logic [N_EP-1:0] i_epStall,
    input  logic [N_EP-1:0] i_inReady,
    input  logic [N_EP-1:0] i_outReady,
    input  logic            i_tx_done,
    output logic            o_tx_start,
    output logic [3:0]      o_tx_pid,
    output logic [3:0]      o_endp,
    output logic            o_outCommit,
    output logic            o_isSetup,
    output logic            o_inConsumed,
    output logic            o_busy
);
    localparam int EP_W = (N_EP > 1) ? $clog2(N_EP) : 1;
    localparam logic [4:0] N_EP_L = 5'(N_EP);

    txnState_t       state, stateNxt;
    logic            curSetup, curSetupNxt;
    logic [3:0]      endpNxt, txPidNxt;
    logic [N_EP-1:0] inToggle, inToggleNxt, outToggle, outToggleNxt;
    logic            txStartNxt, commitNxt, isSetupNxt, consumedNxt;
    logic [EP_W-1:0] tokEp, curEp;
    logic            tokenValid, dataGood, timeout, inWait;

    assign tokEp = i_rx_endp[EP_W-1:0];
    assign curEp = o_endp[EP_W-1:0];
    assign tokenValid = i_rx_eop && i_rx_pidOkay && i_rx_tokenOkay &&
                        (i_rx_addr == i_devAddr) && ({1'b0, i_rx_endp} < N_EP_L);
    assign dataGood = i_rx_eop && i_rx_pidOkay && i_rx_dataOkay && isDataPid(i_rx_pid);
    assign inWait = (state == WAIT_DATA) || (state == WAIT_ACK);
    assign o_busy = (state != IDLE);

    usbfs_turnaround_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .i_clk_48MHz (i_clk_48MHz),
        .i_rst       (i_rst),
        .clear       (!inWait),
        .enable      (inWait),
        .expired     (timeout)
    );

    always_comb begin
        stateNxt     = state;
        curSetupNxt  = curSetup;
        endpNxt      = o_endp;
        txPidNxt     = o_tx_pid;
        inToggleNxt  = inToggle;
        outToggleNxt = outToggle;
        txStartNxt   = 1'b0;
        commitNxt    = 1'b0;
        isSetupNxt   = 1'b0;
        consumedNxt  = 1'b0;
        case (state)
            IDLE: begin
                if (tokenValid) begin
                    case (i_rx_pid)
                        PID_OUT, PID_SETUP: begin
                            endpNxt     = i_rx_endp;
                            curSetupNxt = (i_rx_pid == PID_SETUP);
                            stateNxt    = WAIT_DATA;
                        end
                        PID_IN: begin
                            endpNxt    = i_rx_endp;
                            txStartNxt = 1'b1;
                            stateNxt   = TX_HS;
                            if (i_epStall[tokEp]) begin
                                txPidNxt = PID_STALL;
                            end else if (i_inReady[tokEp]) begin
                                txPidNxt = inToggle[tokEp] ? PID_DATA1 : PID_DATA0;
                                stateNxt = TX_DATA;
                            end else begin
                                txPidNxt = PID_NAK;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            WAIT_DATA: begin
                // A good data packet in the expiry cycle still wins.
                if (dataGood) begin
                    txStartNxt = 1'b1;
                    stateNxt   = TX_HS;
                    txPidNxt   = PID_ACK;
                    if (curSetup) begin
                        commitNxt           = 1'b1;
                        isSetupNxt          = 1'b1;
                        outToggleNxt[curEp] = 1'b1;
                        inToggleNxt[curEp]  = 1'b1;
                    end else if (i_epStall[curEp]) begin
                        txPidNxt = PID_STALL;
                    end else if (!i_outReady[curEp]) begin
                        txPidNxt = PID_NAK;
                    end else if (i_rx_pid[3] == outToggle[curEp]) begin
                        commitNxt           = 1'b1;
                        outToggleNxt[curEp] = !outToggle[curEp];
                    end
                end else if (i_rx_eop || timeout) begin
                    stateNxt = IDLE;
                end
            end
            TX_HS: begin
                if (i_tx_done) stateNxt = IDLE;
            end
            TX_DATA: begin
                if (i_tx_done) stateNxt = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (i_rx_eop) begin
                    stateNxt = IDLE;
                    if (i_rx_pidOkay && (i_rx_pid == PID_ACK)) begin
                        inToggleNxt[curEp] = !inToggle[curEp];
                        consumedNxt        = 1'b1;
                    end
                end else if (timeout) begin
                    stateNxt = IDLE;
                end
            end
            default: stateNxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk_48MHz or posedge i_rst) begin
        if (i_rst) begin
            state        <= IDLE;
            curSetup     <= 1'b0;
            o_endp       <= '0;
            o_tx_pid     <= '0;
            inToggle     <= '0;
            outToggle    <= '0;
            o_tx_start   <= 1'b0;
            o_outCommit  <= 1'b0;
            o_isSetup    <= 1'b0;
            o_inConsumed <= 1'b0;
        end else if (i_usbReset) begin
            state        <= IDLE;
            curSetup     <= 1'b0;
            o_endp       <= '0;
            o_tx_pid     <= '0;
            inToggle     <= '0;
            outToggle    <= '0;
            o_tx_start   <= 1'b0;
            o_outCommit  <= 1'b0;
            o_isSetup    <= 1'b0;
            o_inConsumed <= 1'b0;
        end else begin
            state        <= stateNxt;
            curSetup     <= curSetupNxt;
            o_endp       <= endpNxt;
            o_tx_pid     <= txPidNxt;
            inToggle     <= inToggleNxt;
            outToggle    <= outToggleNxt;
            o_tx_start   <= txStartNxt;
            o_outCommit  <= commitNxt;
            o_isSetup    <= isSetupNxt;
            o_inConsumed <= consumedNxt;
        end
    end

    // The transmitter needs at least one cycle after a start request.
    assert property (@(posedge i_clk_48MHz) disable iff (i_rst) !(o_tx_start && i_tx_done));

endmodule

// File: tb/tb_usbfs_txn_ctrl.sv
// Directed self-checking bench for usbfs_txn_ctrl: OUT/IN/SETUP flows,
// handshake selection, toggles, timeouts, ignored packets and resets.
module tb_usbfs_txn_ctrl;
    import usbfs_txn_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst, usbReset, rxEop, pidOk, tokOk, dataOk, txDone;
    logic [6:0] devAddr, rxAddr;
    logic [3:0] rxPid, rxEndp, epStall, inReady, outReady;
    logic       txStart, outCommit, isSetup, inConsumed, busy;
    logic [3:0] txPid, endp;
    int         checks = 0;
    int         errors = 0;

    always #10 clk = ~clk;

    usbfs_txn_ctrl #(.N_EP(4), .TIMEOUT_CYCLES(72)) dut (
        .i_clk_48MHz    (clk),
        .i_rst          (rst),
        .i_usbReset     (usbReset),
        .i_devAddr      (devAddr),
        .i_rx_eop       (rxEop),
        .i_rx_pid       (rxPid),
        .i_rx_addr      (rxAddr),
        .i_rx_endp      (rxEndp),
        .i_rx_pidOkay   (pidOk),
        .i_rx_tokenOkay (tokOk),
        .i_rx_dataOkay  (dataOk),
        .i_epStall      (epStall),
        .i_inReady      (inReady),
        .i_outReady     (outReady),
        .i_tx_done      (txDone),
        .o_tx_start     (txStart),
        .o_tx_pid       (txPid),
        .o_endp         (endp),
        .o_outCommit    (outCommit),
        .o_isSetup      (isSetup),
        .o_inConsumed   (inConsumed),
        .o_busy         (busy)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle packet; on return outputs reflect the decision made at its eop.
    task automatic send(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] ep,
                        input logic pOk, input logic tOk, input logic dOk);
        rxPid = pid; rxAddr = addr; rxEndp = ep;
        pidOk = pOk; tokOk = tOk; dataOk = dOk; rxEop = 1'b1;
        tick(1);
        rxEop = 1'b0;
    endtask

    task automatic finishTx();
        tick(1);
        txDone = 1'b1;
        tick(1);
        txDone = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        checks++; if (txStart !== 1'b0) begin errors++; $display("FAIL reset_txStart: got %b want 0", txStart); end
        checks++; if (txPid !== 4'h0) begin errors++; $display("FAIL reset_txPid: got %h want 0", txPid); end
        checks++; if (endp !== 4'h0) begin errors++; $display("FAIL reset_endp: got %h want 0", endp); end
        checks++; if ({outCommit, isSetup, inConsumed} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b want 000", {outCommit, isSetup, inConsumed}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_out();
        send(PID_OUT, 7'd5, 4'd1, 1, 1, 1);
        checks++; if (busy !== 1'b1 || txStart !== 1'b0) begin errors++; $display("FAIL out_token: busy %b txStart %b want 1 0", busy, txStart); end
        send(PID_DATA0, 7'd0, 4'd0, 1, 1, 1);
        checks++; if (txStart !== 1'b1 || txPid !== PID_ACK) begin errors++; $display("FAIL out_ack: start %b pid %h want 1 %h", txStart, txPid, PID_ACK); end
        checks++; if (outCommit !== 1'b1 || isSetup !== 1'b0 || endp !== 4'd1) begin errors++; $display("FAIL out_commit: commit %b setup %b endp %h want 1 0 1", outCommit, isSetup, endp); end
        tick(1);
        checks++; if (outCommit !== 1'b0 || txStart !== 1'b0) begin errors++; $display("FAIL out_pulse_width: commit %b start %b want 0 0", outCommit, txStart); end
        txDone = 1'b1; tick(1); txDone = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL out_idle: busy %b want 0", busy); end
        send(PID_OUT, 7'd5, 4'd1, 1, 1, 1);
        send(PID_DATA0, 7'd0, 4'd0, 1, 1, 1);
        checks++; if (txPid !== PID_ACK || outCommit !== 1'b0) begin errors++; $display("FAIL out_retry: pid %h commit %b want %h 0", txPid, outCommit, PID_ACK); end
        finishTx();
        send(PID_OUT, 7'd5, 4'd1, 1, 1, 1);
        send(PID_DATA1, 7'd0, 4'd0, 1, 1, 1);
        checks++; if (txPid !== PID_ACK || outCommit !== 1'b1) begin errors++; $display("FAIL out_data1: pid %h commit %b want %h 1", txPid, outCommit, PID_ACK); end
        finishTx();
    endtask

    task automatic test_in();
        send(PID_IN, 7'd5, 4'd2, 1, 1, 1);
        checks++; if (txStart !== 1'b1 || txPid !== PID_DATA0 || endp !== 4'd2) begin errors++; $display("FAIL in_data0: start %b pid %h endp %h want 1 %h 2", txStart, txPid, endp, PID_DATA0); end
        finishTx();
        tick(71);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL in_timeout_early: busy %b want 1", busy); end
        tick(1);
        checks++; if (busy !== 1'b0 || inConsumed !== 1'b0) begin errors++; $display("FAIL in_timeout: busy %b consumed %b want 0 0", busy, inConsumed); end
        send(PID_IN, 7'd5, 4'd2, 1, 1, 1);
        checks++; if (txPid !== PID_DATA0) begin errors++; $display("FAIL in_resend: pid %h want %h", txPid, PID_DATA0); end
        finishTx();
        send(PID_ACK, 7'd0, 4'd0, 1, 1, 1);
        checks++; if (inConsumed !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL in_consumed: consumed %b busy %b want 1 0", inConsumed, busy); end
        send(PID_IN, 7'd5, 4'd2, 1, 1, 1);
        checks++; if (txPid !== PID_DATA1) begin errors++; $display("FAIL in_data1: pid %h want %h", txPid, PID_DATA1); end
        finishTx();
        send(PID_ACK, 7'd0, 4'd0, 1, 1, 1);
    endtask

    task automatic test_timeout();
        send(PID_OUT, 7'd5, 4'd1, 1, 1, 1);
        tick(72);
        checks++; if (busy !== 1'b0 || txStart !== 1'b0) begin errors++; $display("FAIL wd_timeout: busy %b start %b want 0 0", busy, txStart); end
        send(PID_OUT, 7'd5, 4'd1, 1, 1, 1);
        tick(71);
        send(PID_DATA0, 7'd0, 4'd0, 1, 1, 1);
        checks++; if (txStart !== 1'b1 || txPid !== PID_ACK || outCommit !== 1'b1) begin errors++; $display("FAIL wd_eop_wins: start %b pid %h commit %b want 1 %h 1", txStart, txPid, outCommit, PID_ACK); end
        finishTx();
    endtask

    task automatic test_setup();
        epStall = 4'b0001;
        send(PID_SETUP, 7'd5, 4'd0, 1, 1, 1);
        send(PID_DATA0, 7'd0, 4'd0, 1, 1, 1);
        checks++; if (txPid !== PID_ACK || outCommit !== 1'b1 || isSetup !== 1'b1) begin errors++; $display("FAIL setup_ack: pid %h commit %b setup %b want %h 1 1", txPid, outCommit, isSetup, PID_ACK); end
        finishTx();
        epStall = 4'b0000;
        send(PID_IN, 7'd5, 4'd0, 1, 1, 1);
        checks++; if (txPid !== PID_DATA1) begin errors++; $display("FAIL setup_in_data1: pid %h want %h", txPid, PID_DATA1); end
        finishTx();
        send(PID_ACK, 7'd0, 4'd0, 1, 1, 1);
    endtask

    task automatic test_stall_nak();
        epStall = 4'b1000;
        send(PID_IN, 7'd5, 4'd3, 1, 1, 1);
        checks++; if (txStart !== 1'b1 || txPid !== PID_STALL) begin errors++; $display("FAIL in_stall: start %b pid %h want 1 %h", txStart, txPid, PID_STALL); end
        finishTx();
        epStall = 4'b0000; inReady = 4'b0000;
        send(PID_IN, 7'd5, 4'd1, 1, 1, 1);
        checks++; if (txPid !== PID_NAK) begin errors++; $display("FAIL in_nak: pid %h want %h", txPid, PID_NAK); end
        finishTx();
        outReady = 4'b0000;
        send(PID_OUT, 7'd5, 4'd2, 1, 1, 1);
        send(PID_DATA0, 7'd0, 4'd0, 1, 1, 1);
        checks++; if (txPid !== PID_NAK || outCommit !== 1'b0) begin errors++; $display("FAIL out_nak: pid %h commit %b want %h 0", txPid, outCommit, PID_NAK); end
        finishTx();
        inReady = 4'b1111; outReady = 4'b1111;
    endtask

    task automatic test_ignored();
        send(PID_OUT, 7'd6, 4'd1, 1, 1, 1);
        checks++; if (busy !== 1'b0 || txStart !== 1'b0) begin errors++; $display("FAIL ign_addr: busy %b start %b want 0 0", busy, txStart); end
        send(PID_IN, 7'd5, 4'd1, 1, 0, 1);
        checks++; if (busy !== 1'b0 || txStart !== 1'b0) begin errors++; $display("FAIL ign_crc5: busy %b start %b want 0 0", busy, txStart); end
        send(PID_IN, 7'd5, 4'd4, 1, 1, 1);
        checks++; if (busy !== 1'b0 || txStart !== 1'b0) begin errors++; $display("FAIL ign_endp: busy %b start %b want 0 0", busy, txStart); end
        send(PID_SOF, 7'd5, 4'd1, 1, 1, 1);
        checks++; if (busy !== 1'b0 || txStart !== 1'b0) begin errors++; $display("FAIL ign_sof: busy %b start %b want 0 0", busy, txStart); end
        send(PID_OUT, 7'd5, 4'd1, 1, 1, 1);
        send(PID_DATA1, 7'd0, 4'd0, 1, 1, 0);
        checks++; if (busy !== 1'b0 || txStart !== 1'b0 || outCommit !== 1'b0) begin errors++; $display("FAIL ign_crc16: busy %b start %b commit %b want 0 0 0", busy, txStart, outCommit); end
    endtask

    task automatic test_resets();
        // inToggle[2]=0, outToggle[1]=1 on entry
        send(PID_IN, 7'd5, 4'd2, 1, 1, 1);
        finishTx();
        send(PID_ACK, 7'd0, 4'd0, 1, 1, 1);
        send(PID_IN, 7'd5, 4'd2, 1, 1, 1);
        checks++; if (txPid !== PID_DATA1) begin errors++; $display("FAIL rs_pre_data1: pid %h want %h", txPid, PID_DATA1); end
        finishTx();
        usbReset = 1'b1; tick(1); usbReset = 1'b0;
        checks++; if (busy !== 1'b0 || txPid !== 4'h0 || endp !== 4'h0) begin errors++; $display("FAIL usbreset_clear: busy %b pid %h endp %h want 0 0 0", busy, txPid, endp); end
        send(PID_ACK, 7'd0, 4'd0, 1, 1, 1);
        checks++; if (inConsumed !== 1'b0) begin errors++; $display("FAIL usbreset_no_consume: consumed %b want 0", inConsumed); end
        send(PID_IN, 7'd5, 4'd2, 1, 1, 1);
        checks++; if (txPid !== PID_DATA0) begin errors++; $display("FAIL usbreset_intoggle: pid %h want %h", txPid, PID_DATA0); end
        finishTx();
        send(PID_ACK, 7'd0, 4'd0, 1, 1, 1);
        send(PID_IN, 7'd5, 4'd2, 1, 1, 1);
        tick(1);
        #5 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || txPid !== 4'h0 || txStart !== 1'b0) begin errors++; $display("FAIL async_rst: busy %b pid %h start %b want 0 0 0", busy, txPid, txStart); end
        tick(2);
        rst = 1'b0;
        tick(3);
        checks++; if ({txStart, outCommit, inConsumed, busy} !== 4'b0000) begin errors++; $display("FAIL rst_quiet: got %b want 0000", {txStart, outCommit, inConsumed, busy}); end
        send(PID_IN, 7'd5, 4'd2, 1, 1, 1);
        checks++; if (txPid !== PID_DATA0) begin errors++; $display("FAIL rst_intoggle: pid %h want %h", txPid, PID_DATA0); end
        finishTx();
        tick(72);
        send(PID_OUT, 7'd5, 4'd1, 1, 1, 1);
        send(PID_DATA0, 7'd0, 4'd0, 1, 1, 1);
        checks++; if (outCommit !== 1'b1) begin errors++; $display("FAIL rst_outtoggle: commit %b want 1", outCommit); end
        finishTx();
    endtask

    initial begin
        rst = 1'b1; usbReset = 1'b0; devAddr = 7'd5;
        rxEop = 1'b0; rxPid = 4'h0; rxAddr = 7'd0; rxEndp = 4'd0;
        pidOk = 1'b0; tokOk = 1'b0; dataOk = 1'b0; txDone = 1'b0;
        epStall = 4'b0000; inReady = 4'b1111; outReady = 4'b1111;
        test_reset();
        test_out();
        test_in();
        test_timeout();
        test_setup();
        test_stall_nak();
        test_ignored();
        test_resets();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
